// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation/state types and helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DONE
  } state_e;

  // Callers truncate to their own XLEN.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: unsigned restoring divider, one quotient bit per cycle, XLEN cycles after start.
module muldiv_divider #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q;
  logic [XLEN:0]   shifted;
  logic            fits;

  // A zero divisor always fits, so the quotient fills with ones and the dividend shifts into rem_q.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, divisor};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (kill) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
    end else if (active && cnt != LAST) begin
      rem_q <= fits ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt   <= cnt + 1'b1;
    end
  end

  assign done      = active && (cnt == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide execute unit with valid/ready on both sides.
// Optional macro MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and zero-operand MUL finish early.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_UNROLL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int unsigned   MUL_STEPS = XLEN / MUL_UNROLL;
  localparam int unsigned   CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_STEPS);

  state_e            state_q, state_d;
  muldiv_op_e        op_in, op_q;
  logic              word_eff, word_q, is_mulh, is_div, is_rem, zext_w;
  logic              a_signed, b_signed, a_neg, b_neg, res_neg, neg_q;
  logic              accept, early, early_q;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_mag_q;
  logic [XLEN-1:0]   early_val, early_val_q, result_q, sel, final_res;
  logic [2*XLEN-1:0] acc_q, acc_step, raw, signed_raw;
  logic [2*XLEN:0]   t;
  logic [CW-1:0]     cnt_q;
  logic              div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign op_in = muldiv_op_e'(op);

  always_comb begin
    is_mulh  = op_in inside {OP_MULH, OP_MULHSU, OP_MULHU};
    is_div   = op_in[2];
    is_rem   = op_in inside {OP_REM, OP_REMU};
    zext_w   = op_in inside {OP_DIVU, OP_REMU};
    word_eff = word && (XLEN == 64) && !is_mulh;
    a_ext    = rs1;
    b_ext    = rs2;
    if (word_eff) begin
      a_ext = zext_w ? XLEN'({32'b0, rs1[31:0]}) : XLEN'(sext32(rs1[31:0]));
      b_ext = zext_w ? XLEN'({32'b0, rs2[31:0]}) : XLEN'(sext32(rs2[31:0]));
    end
    a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed && a_ext[XLEN-1];
    b_neg    = b_signed && b_ext[XLEN-1];
    a_mag    = a_neg ? ('0 - a_ext) : a_ext;
    b_mag    = b_neg ? ('0 - b_ext) : b_ext;
    // A zero divisor keeps the all-ones quotient un-negated.
    if (!is_div)     res_neg = a_neg ^ b_neg;
    else if (is_rem) res_neg = a_neg;
    else             res_neg = (a_neg ^ b_neg) && (b_ext != '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] most_neg;
  logic            div_zero, div_ovf;

  always_comb begin
    most_neg  = word_eff ? XLEN'(sext32(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = (b_ext == '0);
    div_ovf   = a_signed && (a_ext == most_neg) && (b_ext == '1);
    early     = is_div ? (div_zero || div_ovf) : ((a_ext == '0) || (b_ext == '0));
    early_val = '0;
    if (is_div && div_zero)     early_val = is_rem ? a_ext : '1;
    else if (is_div && div_ovf) early_val = is_rem ? '0 : a_ext;
  end
`else
  assign early     = 1'b0;
  assign early_val = '0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = (is_div && !early) ? ST_DIV : ST_MUL;
      end
      ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    t = {1'b0, acc_q};
    for (int unsigned i = 0; i < MUL_UNROLL; i++) begin
      if (t[0]) t[2*XLEN:XLEN] = t[2*XLEN:XLEN] + {1'b0, a_mag_q};
      t = t >> 1;
    end
    acc_step = t[2*XLEN-1:0];
  end

  always_comb begin
    raw        = op_q[2] ? {{XLEN{1'b0}}, (op_q inside {OP_REM, OP_REMU}) ? div_rem : div_quo} : acc_q;
    signed_raw = neg_q ? ('0 - raw) : raw;
    sel        = (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? signed_raw[2*XLEN-1:XLEN]
                                                                : signed_raw[XLEN-1:0];
    if (early_q) sel = early_val_q;
    final_res  = word_q ? XLEN'(sext32(sel[31:0])) : sel;
  end

  // Early-out enters ST_MUL with the counter at its last value, so it still spends one finalise cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      a_mag_q     <= '0;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      early_q     <= 1'b0;
      early_val_q <= '0;
      result_q    <= '0;
    end else if (accept) begin
      op_q        <= op_in;
      word_q      <= word_eff;
      neg_q       <= res_neg;
      a_mag_q     <= a_mag;
      acc_q       <= {{XLEN{1'b0}}, b_mag};
      cnt_q       <= early ? MUL_LAST : '0;
      early_q     <= early;
      early_val_q <= early_val;
    end else if (state_q == ST_MUL && !flush) begin
      if (cnt_q == MUL_LAST) begin
        result_q <= final_res;
      end else begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (state_q == ST_DIV && !flush && div_done) begin
      result_q <= final_res;
    end
  end

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div && !early),
    .kill      (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed RV64M cases and randomized ops.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] rs1, rs2, result;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .MUL_UNROLL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: RISC-V M semantics computed with wide arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w_in,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic         w;
    longint       sa, sb;
    longint unsigned ua, ub;
    int           sa32, sb32;
    int unsigned  ua32, ub32;
    logic [63:0]  q, r;
    w = w_in && !(o inside {3'd1, 3'd2, 3'd3});
    case (o)
      3'd0: begin p = {64'b0, a} * {64'b0, b}; return w ? sx32(p[31:0]) : p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      default: ;
    endcase
    if (w) begin
      if (o[0]) begin
        ua32 = a[31:0]; ub32 = b[31:0];
        if (ub32 == 0) begin q = '1; r = 64'(ua32); end
        else begin q = 64'(ua32 / ub32); r = 64'(ua32 % ub32); end
      end else begin
        sa32 = a[31:0]; sb32 = b[31:0];
        if (sb32 == 0) begin q = '1; r = 64'(sa32); end
        else if (sa32 == int'(32'h8000_0000) && sb32 == -1) begin q = 64'(sa32); r = '0; end
        else begin q = 64'(sa32 / sb32); r = 64'(sa32 % sb32); end
      end
      return sx32(o[1] ? r[31:0] : q[31:0]);
    end
    if (o[0]) begin
      ua = a; ub = b;
      if (ub == 0) begin q = '1; r = a; end
      else begin q = ua / ub; r = ua % ub; end
    end else begin
      sa = a; sb = b;
      if (sb == 0) begin q = '1; r = a; end
      else if (a == 64'h8000_0000_0000_0000 && sb == -1) begin q = a; r = '0; end
      else begin q = sa / sb; r = sa % sb; end
    end
    return o[1] ? r : q;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'h0 - 64'($urandom_range(1, 20));
      5: return {32'hFFFF_FFFF, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got 0x%016h with empty scoreboard", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    ok = in_ready;
    if (!ok) begin timeout_fail("in_ready_wait"); return; end
    op = o; word = w; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] e, input int hold, input int lat);
    bit ok;
    int n;
    out_ready = (hold == 0);
    exp_q.push_back(e);
    issue(o, w, a, b, ok);
    if (!ok) begin void'(exp_q.pop_back()); out_ready = 1'b1; return; end
    wait_valid(n);
    if (!out_valid) begin timeout_fail("out_valid_wait"); out_ready = 1'b1; return; end
    check("latency", 64'(n), 64'(lat));
    if (hold > 0) begin
      repeat (hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", result, e);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_hs", 64'(in_ready), 64'd1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bit seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; op = '0; word = 1'b0; rs1 = '0; rs2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 17);
    run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 17);
    // Backpressure for 10 cycles, then back-to-back issue right after the handshake.
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 10, 17);
    run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 65);
    run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 65);
    run_op(3'd5, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 65);
    run_op(3'd7, 1'b0, 64'd7, 64'd0, 64'd7, 0, 65);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 65);
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0, 65);
    run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, 65);
    run_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, 0, 65);
    run_op(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 17);
    run_op(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0, 65);

    // Flush on the fifth cycle of a divide: no result, idle next cycle.
    issue(3'd4, 1'b0, 64'd1000, 64'd3, ok);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("flush_no_result", 64'(seen), 64'd0);

    // Flush coinciding with out_ready: the result is dropped, no handshake.
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd5, 64'd6, ok);
    wait_valid(n);
    if (!out_valid) timeout_fail("flush_done_wait");
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_in_ready", 64'(in_ready), 64'd1);

    run_op(3'd0, 1'b0, 64'd12345, 64'd678, 64'd8369910, 0, 17);

    // Async reset in the middle of a multiply.
    issue(3'd0, 1'b0, 64'd99, 64'd77, ok);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = ($urandom_range(0, 3) == 0);
      ra = rnd_operand();
      rb = rnd_operand();
      run_op(ro, rw, ra, rb, ref_model(ro, rw, ra, rb),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, ro[2] ? 65 : 17);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
